// File: rtl/wam_game_core_if.sv
// Bundle of game-side signals between the whack-a-mole rule engine and its
// neighbours (light controller, keypad, HEX decoders, debug monitor).
//
// Event signalling: light_on, light_off, key_valid are single-cycle strobes with
// no back-pressure. The engine is always ready and samples each strobe, together
// with its qualifier (light_pos / key), on the rising clk edge where the strobe is
// high. hit_pulse / miss_pulse are single-cycle strobes in the other direction.
interface wam_game_core_if #(
  parameter int POS_W = 4
) ();
  // Controls and events into the engine
  logic             start;
  logic [3:0]       difficulty;
  logic [3:0]       gamemode;
  logic             extended;
  logic             light_on;
  logic             light_off;
  logic [POS_W-1:0] light_pos;
  logic             key_valid;
  logic [POS_W-1:0] key;
  // Game state out of the engine
  logic [27:0]      time_on;
  logic [27:0]      time_between;
  logic             playing;
  logic             game_over;
  logic [6:0]       score;
  logic [6:0]       disp_right;
  logic [1:0]       lives_left;
  logic [1:0]       level;
  logic             hit_pulse;
  logic             miss_pulse;
  logic [1:0]       state_dbg;

  modport slave (
    input  start, difficulty, gamemode, extended,
    input  light_on, light_off, light_pos, key_valid, key,
    output time_on, time_between, playing, game_over, score, disp_right,
    output lives_left, level, hit_pulse, miss_pulse, state_dbg
  );

  modport master (
    output start, difficulty, gamemode, extended,
    output light_on, light_off, light_pos, key_valid, key,
    input  time_on, time_between, playing, game_over, score, disp_right,
    input  lives_left, level, hit_pulse, miss_pulse, state_dbg
  );
endinterface

// File: rtl/wam_game_core.sv
// Whack-a-mole game-rule engine: runs one game (IDLE -> PLAY -> OVER) in one of
// four modes (NORMAL, TIMED, DEATH, LEVEL), scores hits/misses of the lit light,
// and publishes score, lives, level, countdown and per-light timing.
// Optional feature macro: WAM_STREAK_BONUS_EN (every 5th consecutive hit scores +2).
// state_dbg exposes the FSM state: 0 IDLE, 1 PLAY, 2 OVER.
module wam_game_core #(
  parameter int N_LIGHTS   = 9,
  parameter int POS_W      = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int GAME_SECS  = 60,
  parameter int LIVES      = 3,
  parameter int LEVEL_STEP = 5
) (
  input logic             clk,
  input logic             reset,
  wam_game_core_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;
  typedef enum logic [1:0] {M_NORMAL = 2'd0, M_TIMED = 2'd1, M_DEATH = 2'd2, M_LEVEL = 2'd3} mode_t;

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [27:0] T_2S    = 28'(2 * CLK_HZ - 1);
  localparam logic [27:0] T_1S    = 28'(CLK_HZ - 1);
  localparam logic [27:0] T_HALF  = 28'(CLK_HZ / 2 - 1);
  localparam logic [27:0] T_QUART = 28'(CLK_HZ / 4 - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d, mode_in;
  logic [1:0]       diff_q, diff_d, diff_in;
  logic             ext_q, ext_d;
  logic [6:0]       score_q, score_d;
  logic [5:0]       flicks_q, flicks_d;
  logic [1:0]       lives_q, lives_d;
  logic [6:0]       secs_q, secs_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             armed_q, armed_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       level_q, level_d;
  logic [6:0]       lvl_cnt_q, lvl_cnt_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             start_prev_q, start_prev_d;
  logic [27:0]      time_on_q, time_on_d;
  logic [27:0]      time_btw_q, time_btw_d;
  logic [6:0]       disp_q, disp_d;
`ifdef WAM_STREAK_BONUS_EN
  logic [2:0]       streak_q, streak_d;
`endif

  logic       start_rise;
  logic       key_in_range;
  logic       key_ev;
  logic       hit;
  logic       miss;
  logic [5:0] max_flicks;
  logic [5:0] max_flicks_d;
  logic [7:0] score_sum;
  logic [7:0] score_inc;
  logic [1:0] row;

  // Keys outside the light range cannot correspond to any light, so they are dropped.
  assign start_rise   = bus.start & ~start_prev_q;
  assign key_in_range = (int'(bus.key) < N_LIGHTS);
  assign key_ev       = bus.key_valid & key_in_range & armed_q;
  assign hit          = key_ev & (bus.key == pos_q);
  // A key press on the armed light is judged before a same-cycle expiry.
  assign miss         = (key_ev & (bus.key != pos_q)) | (bus.light_off & armed_q & ~key_ev);
  assign max_flicks   = ext_q ? 6'd50 : 6'd25;

  // Decode the one-hot mode and difficulty selects; anything else falls back to NORMAL / L2.
  always_comb begin
    mode_in = M_NORMAL;
    case (bus.gamemode)
      4'b0010: mode_in = M_TIMED;
      4'b0100: mode_in = M_DEATH;
      4'b1000: mode_in = M_LEVEL;
      default: mode_in = M_NORMAL;
    endcase
    diff_in = 2'd1;
    case (bus.difficulty)
      4'b0001: diff_in = 2'd0;
      4'b0010: diff_in = 2'd1;
      4'b0100: diff_in = 2'd2;
      4'b1000: diff_in = 2'd3;
      default: diff_in = 2'd1;
    endcase
  end

  // Next-state computation for the game FSM and all game counters.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    diff_d       = diff_q;
    ext_d        = ext_q;
    score_d      = score_q;
    flicks_d     = flicks_q;
    lives_d      = lives_q;
    secs_d       = secs_q;
    presc_d      = presc_q;
    armed_d      = armed_q;
    pos_d        = pos_q;
    level_d      = level_q;
    lvl_cnt_d    = lvl_cnt_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    start_prev_d = bus.start;
    score_inc    = 8'd1;
    score_sum    = 8'd0;
`ifdef WAM_STREAK_BONUS_EN
    streak_d     = streak_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_d   = S_PLAY;
          mode_d    = mode_in;
          diff_d    = diff_in;
          ext_d     = bus.extended;
          score_d   = 7'd0;
          flicks_d  = 6'd0;
          lives_d   = 2'(LIVES);
          secs_d    = 7'(GAME_SECS);
          presc_d   = '0;
          armed_d   = 1'b0;
          level_d   = 2'd0;
          lvl_cnt_d = 7'd0;
`ifdef WAM_STREAK_BONUS_EN
          streak_d  = 3'd0;
`endif
        end
      end
      S_PLAY: begin
        if (hit) begin
          hit_d = 1'b1;
`ifdef WAM_STREAK_BONUS_EN
          if (streak_q == 3'd4) begin
            score_inc = 8'd2;
            streak_d  = 3'd0;
          end else begin
            streak_d  = streak_q + 3'd1;
          end
`endif
          score_sum = {1'b0, score_q} + score_inc;
          score_d   = (score_sum > 8'd99) ? 7'd99 : score_sum[6:0];
          if (mode_q == M_LEVEL) begin
            if (lvl_cnt_q == 7'(LEVEL_STEP - 1)) begin
              lvl_cnt_d = 7'd0;
              if (level_q != 2'd3) level_d = level_q + 2'd1;
            end else begin
              lvl_cnt_d = lvl_cnt_q + 7'd1;
            end
          end
        end
        if (miss) begin
          miss_d = 1'b1;
`ifdef WAM_STREAK_BONUS_EN
          streak_d = 3'd0;
`endif
          if (mode_q == M_DEATH) begin
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) state_d = S_OVER;
          end
        end
        if (hit | miss) armed_d = 1'b0;
        // The old light is judged first, then a same-cycle new light arms.
        if (bus.light_on) begin
          armed_d = 1'b1;
          pos_d   = bus.light_pos;
          if (flicks_q != max_flicks) flicks_d = flicks_q + 6'd1;
        end
        // The last flick ends the game when it is resolved, not when it is lit.
        if ((hit | miss) && (mode_q == M_NORMAL || mode_q == M_LEVEL) && flicks_q == max_flicks)
          state_d = S_OVER;
        if (mode_q == M_TIMED) begin
          if (presc_q == PW'(CLK_HZ - 1)) begin
            presc_d = '0;
            if (secs_q != 7'd0) secs_d = secs_q - 7'd1;
            if (secs_q == 7'd1) state_d = S_OVER;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered display/timing outputs derived from the next game configuration.
  always_comb begin
    row          = (mode_d == M_LEVEL) ? level_d : diff_d;
    max_flicks_d = ext_d ? 6'd50 : 6'd25;
    time_on_d    = T_1S;
    time_btw_d   = T_1S;
    case (row)
      2'd0: begin time_on_d = T_2S;   time_btw_d = T_2S;    end
      2'd1: begin time_on_d = T_1S;   time_btw_d = T_1S;    end
      2'd2: begin time_on_d = T_1S;   time_btw_d = T_HALF;  end
      default: begin time_on_d = T_HALF; time_btw_d = T_QUART; end
    endcase
    // The right display stays blank until the first game starts.
    if (state_d == S_IDLE) disp_d = disp_q;
    else if (mode_d == M_TIMED) disp_d = secs_d;
    else disp_d = {1'b0, max_flicks_d};
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mode_q       <= M_NORMAL;
      diff_q       <= 2'd1;
      ext_q        <= 1'b0;
      score_q      <= 7'd0;
      flicks_q     <= 6'd0;
      lives_q      <= 2'd0;
      secs_q       <= 7'd0;
      presc_q      <= '0;
      armed_q      <= 1'b0;
      pos_q        <= '0;
      level_q      <= 2'd0;
      lvl_cnt_q    <= 7'd0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      start_prev_q <= 1'b0;
      time_on_q    <= T_1S;
      time_btw_q   <= T_1S;
      disp_q       <= 7'd0;
`ifdef WAM_STREAK_BONUS_EN
      streak_q     <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      diff_q       <= diff_d;
      ext_q        <= ext_d;
      score_q      <= score_d;
      flicks_q     <= flicks_d;
      lives_q      <= lives_d;
      secs_q       <= secs_d;
      presc_q      <= presc_d;
      armed_q      <= armed_d;
      pos_q        <= pos_d;
      level_q      <= level_d;
      lvl_cnt_q    <= lvl_cnt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      start_prev_q <= start_prev_d;
      time_on_q    <= time_on_d;
      time_btw_q   <= time_btw_d;
      disp_q       <= disp_d;
`ifdef WAM_STREAK_BONUS_EN
      streak_q     <= streak_d;
`endif
    end
  end

  assign bus.time_on      = time_on_q;
  assign bus.time_between = time_btw_q;
  assign bus.playing      = (state_q == S_PLAY);
  assign bus.game_over    = (state_q == S_OVER);
  assign bus.score        = score_q;
  assign bus.disp_right   = disp_q;
  assign bus.lives_left   = (mode_q == M_DEATH) ? lives_q : 2'd0;
  assign bus.level        = level_q;
  assign bus.hit_pulse    = hit_q;
  assign bus.miss_pulse   = miss_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_wam_game_core.sv
// Directed bench for wam_game_core with CLK_HZ=100 so one game second is 100 cycles.
module tb_wam_game_core;

`ifdef WAM_STREAK_BONUS_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [6:0] exp_q[$];

  wam_game_core_if #(.POS_W(4)) bus ();

  wam_game_core #(
    .N_LIGHTS(9), .POS_W(4), .CLK_HZ(100), .GAME_SECS(3), .LIVES(3), .LEVEL_STEP(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic light(input logic [3:0] p);
    bus.light_on = 1'b1; bus.light_pos = p;
    tick();
    bus.light_on = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1; bus.key = k;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic expire();
    bus.light_off = 1'b1;
    tick();
    bus.light_off = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] gm, input logic [3:0] df, input logic ex);
    bus.gamemode = gm; bus.difficulty = df; bus.extended = ex;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    int exp_score;
    logic [1:0]  lvl_tab[4]    = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [27:0] ton_tab[4]    = '{28'd99, 28'd99, 28'd49, 28'd49};
    logic [27:0] tbtw_tab[4]   = '{28'd99, 28'd49, 28'd24, 28'd24};

    bus.start = 1'b0; bus.difficulty = 4'd0; bus.gamemode = 4'd0; bus.extended = 1'b0;
    bus.light_on = 1'b0; bus.light_off = 1'b0; bus.light_pos = 4'd0;
    bus.key_valid = 1'b0; bus.key = 4'd0;
    reset = 1'b1;
    #3 reset = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_playing", 32'(bus.playing), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    chk("rst_disp", 32'(bus.disp_right), 32'd0);
    chk("rst_lives", 32'(bus.lives_left), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_time_on", 32'(bus.time_on), 32'd99);
    chk("rst_time_btw", 32'(bus.time_between), 32'd99);
    reset = 1'b1;
    tick();

    // NORMAL, L2, 25 flicks all hit
    do_start(4'b0001, 4'b0010, 1'b0);
    chk("n_playing", 32'(bus.playing), 32'd1);
    chk("n_disp", 32'(bus.disp_right), 32'd25);
    chk("n_lives_hidden", 32'(bus.lives_left), 32'd0);
    exp_score = 0;
    for (int i = 0; i < 25; i++) begin
      light(4'(i % 9));
      press(4'(i % 9));
      exp_score += ((i % 5) == 4 && BONUS == 1) ? 2 : 1;
      exp_q.push_back(7'(exp_score));
      chk("n_hit_pulse", 32'(bus.hit_pulse), 32'd1);
      chk("n_miss_pulse", 32'(bus.miss_pulse), 32'd0);
      chk("n_score", 32'(bus.score), 32'(exp_q.pop_front()));
      if (i == 23) chk("n_not_over_24", 32'(bus.game_over), 32'd0);
    end
    chk("n_over", 32'(bus.game_over), 32'd1);
    chk("n_playing_off", 32'(bus.playing), 32'd0);
    tick();
    chk("n_pulse_clear", 32'(bus.hit_pulse), 32'd0);
    light(4'd3); press(4'd3);
    chk("over_no_hit", 32'(bus.hit_pulse), 32'd0);
    chk("over_score_hold", 32'(bus.score), 32'(exp_score));

    // DEATH, L4, three expiries
    do_start(4'b0100, 4'b1000, 1'b0);
    chk("d_lives_init", 32'(bus.lives_left), 32'd3);
    chk("d_score_clr", 32'(bus.score), 32'd0);
    chk("d_time_on_l4", 32'(bus.time_on), 32'd49);
    chk("d_time_btw_l4", 32'(bus.time_between), 32'd24);
    press(4'd3);
    chk("d_unarmed_key", 32'(bus.miss_pulse), 32'd0);
    chk("d_unarmed_lives", 32'(bus.lives_left), 32'd3);
    for (int k = 0; k < 3; k++) begin
      light(4'd2);
      tick();
      expire();
      chk("d_miss_pulse", 32'(bus.miss_pulse), 32'd1);
      chk("d_lives", 32'(bus.lives_left), 32'(2 - k));
      chk("d_over", 32'(bus.game_over), (k == 2) ? 32'd1 : 32'd0);
    end

    // TIMED, non-one-hot difficulty falls back to L2
    do_start(4'b0010, 4'b0011, 1'b0);
    chk("t_time_on", 32'(bus.time_on), 32'd99);
    chk("t_time_btw", 32'(bus.time_between), 32'd99);
    chk("t_disp3", 32'(bus.disp_right), 32'd3);
    repeat (99) tick();
    chk("t_disp3_hold", 32'(bus.disp_right), 32'd3);
    tick();
    chk("t_disp2", 32'(bus.disp_right), 32'd2);
    repeat (100) tick();
    chk("t_disp1", 32'(bus.disp_right), 32'd1);
    chk("t_not_over", 32'(bus.game_over), 32'd0);
    repeat (100) tick();
    chk("t_disp0", 32'(bus.disp_right), 32'd0);
    chk("t_over", 32'(bus.game_over), 32'd1);
    repeat (100) tick();
    chk("t_disp_hold", 32'(bus.disp_right), 32'd0);

    // LEVEL, L1 difficulty ignored after level-up, extended flicks
    do_start(4'b1000, 4'b0001, 1'b1);
    chk("l_level0", 32'(bus.level), 32'd0);
    chk("l_time_on0", 32'(bus.time_on), 32'd199);
    chk("l_time_btw0", 32'(bus.time_between), 32'd199);
    chk("l_disp50", 32'(bus.disp_right), 32'd50);
    for (int h = 1; h <= 20; h++) begin
      light(4'(h % 9));
      press(4'(h % 9));
      if (h % 5 == 0) begin
        chk("l_level", 32'(bus.level), 32'(lvl_tab[h / 5 - 1]));
        chk("l_time_on", 32'(bus.time_on), 32'(ton_tab[h / 5 - 1]));
        chk("l_time_btw", 32'(bus.time_between), 32'(tbtw_tab[h / 5 - 1]));
      end
    end
    chk("l_still_playing", 32'(bus.playing), 32'd1);

    // Asynchronous reset mid-game
    reset = 1'b0;
    #2;
    chk("ar_playing", 32'(bus.playing), 32'd0);
    chk("ar_score", 32'(bus.score), 32'd0);
    chk("ar_level", 32'(bus.level), 32'd0);
    chk("ar_hit_pulse", 32'(bus.hit_pulse), 32'd0);
    chk("ar_disp", 32'(bus.disp_right), 32'd0);
    chk("ar_time_on", 32'(bus.time_on), 32'd99);
    reset = 1'b1;
    tick();

    // Same-cycle event ordering
    do_start(4'b0001, 4'b0010, 1'b0);
    light(4'd4);
    bus.key_valid = 1'b1; bus.key = 4'd4; bus.light_off = 1'b1;
    tick();
    bus.key_valid = 1'b0; bus.light_off = 1'b0;
    chk("s_keyoff_hit", 32'(bus.hit_pulse), 32'd1);
    chk("s_keyoff_nomiss", 32'(bus.miss_pulse), 32'd0);
    chk("s_keyoff_score", 32'(bus.score), 32'd1);
    light(4'd5);
    bus.light_on = 1'b1; bus.light_pos = 4'd7; bus.key_valid = 1'b1; bus.key = 4'd5;
    tick();
    bus.light_on = 1'b0; bus.key_valid = 1'b0;
    chk("s_keyon_hit_old", 32'(bus.hit_pulse), 32'd1);
    chk("s_keyon_score", 32'(bus.score), 32'd2);
    press(4'd7);
    chk("s_new_armed_hit", 32'(bus.hit_pulse), 32'd1);
    chk("s_new_score", 32'(bus.score), 32'd3);
    light(4'd1); press(4'd2);
    chk("s_wrong_miss", 32'(bus.miss_pulse), 32'd1);
    chk("s_wrong_nohit", 32'(bus.hit_pulse), 32'd0);
    chk("s_wrong_score", 32'(bus.score), 32'd3);
    reset = 1'b0;
    #2;
    chk("ar2_playing", 32'(bus.playing), 32'd0);
    chk("ar2_score", 32'(bus.score), 32'd0);
    chk("ar2_miss", 32'(bus.miss_pulse), 32'd0);
    reset = 1'b1;
    tick();

`ifdef WAM_STREAK_BONUS_EN
    // Streak bonus: fifth consecutive hit scores +2, a miss restarts the streak
    do_start(4'b0001, 4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      light(4'(i)); press(4'(i));
    end
    chk("b_score6", 32'(bus.score), 32'd6);
    light(4'd0); press(4'd1);
    light(4'd2); press(4'd2);
    chk("b_score7", 32'(bus.score), 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
